// File: rtl/wb_commit.sv
// -----------------------------------------------------------------------------
// wb_commit -- writeback / commit stage
//
// Purpose:
//   Takes the MEM/WB pipeline register contents, selects the writeback value,
//   commits it into the register file, advances the program counter and counts
//   retired instructions. Provides two combinational read ports on the register
//   file and a combinational mirror of the write-port activity.
//
// Parameters:
//   NREG      register-file depth (power of two, 2..32); register 0 reads 0
//   PC_RESET  PC value loaded on reset
//
// Configuration macro:
//   WB_COMMIT_BYPASS_EN  when defined, the read ports forward the in-flight
//                        writeback value for a matching index; when undefined,
//                        a same-cycle write becomes visible after the edge.
//
// Ports:
//   clk                   single clock, all state updates on the rising edge
//   rst                   synchronous active-high reset
//   valid                 writeback instruction valid (0 = bubble)
//   stall                 hold pc when 1 (register writes still commit)
//   regwrite, memtoreg, branch, j, jmem, and_gate   MEM/WB control
//   write_destination     destination index (low log2(NREG) bits used)
//   read_data_memory      load data / indirect jump target
//   alu_output            ALU result
//   adder1_output         pc+1 from the fetch adder (link value, fall-through)
//   result_shift_jump     direct jump target
//   result_adder_branch   branch target
//   ra_addr, rb_addr      read indices (low log2(NREG) bits used)
//   ra_data, rb_data      combinational read data
//   pc                    registered program counter
//   retired               registered retired-instruction count (wraps)
//   wb_we, wb_addr, wb_data   combinational view of the write port
// -----------------------------------------------------------------------------
module wb_commit #(
  parameter int          NREG     = 16,
  parameter logic [19:0] PC_RESET = 20'h00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        stall,
  input  logic        regwrite,
  input  logic        memtoreg,
  input  logic        branch,
  input  logic        j,
  input  logic        jmem,
  input  logic        and_gate,
  input  logic [19:0] write_destination,
  input  logic [19:0] read_data_memory,
  input  logic [19:0] alu_output,
  input  logic [19:0] adder1_output,
  input  logic [19:0] result_shift_jump,
  input  logic [19:0] result_adder_branch,
  input  logic [4:0]  ra_addr,
  input  logic [4:0]  rb_addr,
  output logic [19:0] ra_data,
  output logic [19:0] rb_data,
  output logic [19:0] pc,
  output logic [15:0] retired,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [19:0] wb_data
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  // Only the low AW bits of the index inputs are meaningful; the rest are
  // folded into a sink so that dropping them is explicit.
  logic unused_ok;
  assign unused_ok = &{1'b0, write_destination, ra_addr, rb_addr};

  logic [AW-1:0] w_idx;
  logic [AW-1:0] a_idx;
  logic [AW-1:0] b_idx;

  assign w_idx = write_destination[AW-1:0];
  assign a_idx = ra_addr[AW-1:0];
  assign b_idx = rb_addr[AW-1:0];

  // ---------------------------------------------------------------------------
  // Write port
  // ---------------------------------------------------------------------------
  // A jump's link value (pc+1) takes precedence over load and ALU results.
  // A jump without regwrite leaves wb_we low, so it only redirects the PC.
  logic [19:0] wb_value;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned, which would infer a latch.
    wb_value = alu_output;
    if (j)             wb_value = adder1_output;
    else if (memtoreg) wb_value = read_data_memory;
  end

  assign wb_data = wb_value;
  assign wb_we   = valid & regwrite & (w_idx != '0);
  assign wb_addr = 5'(w_idx);

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [19:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is cleared on reset because architectural
      // state must read 0 afterwards; storage that only needs valid data
      // before first use would normally be left unreset.
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_we) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values, matching the hardware.
      regs[w_idx] <= wb_data;
    end
  end

  // Stored values; index 0 is forced to zero regardless of its storage.
  logic [19:0] a_stored;
  logic [19:0] b_stored;

  assign a_stored = (a_idx == '0) ? 20'h00000 : regs[a_idx];
  assign b_stored = (b_idx == '0) ? 20'h00000 : regs[b_idx];

`ifdef WB_COMMIT_BYPASS_EN
  // Forward the value being written this cycle. wb_we is never set for
  // index 0, so register 0 still reads zero.
  assign ra_data = (wb_we && (a_idx == w_idx)) ? wb_data : a_stored;
  assign rb_data = (wb_we && (b_idx == w_idx)) ? wb_data : b_stored;
`else
  assign ra_data = a_stored;
  assign rb_data = b_stored;
`endif

  // ---------------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------------
  // A bubble still advances the PC by one; a valid instruction picks its
  // target by priority jmem > j > taken branch > fall-through.
  logic [19:0] pc_next;

  always_comb begin
    pc_next = pc + 20'd1;
    if (valid) begin
      if (jmem)                   pc_next = read_data_memory;
      else if (j)                 pc_next = result_shift_jump;
      else if (branch & and_gate) pc_next = result_adder_branch;
      else                        pc_next = adder1_output;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= PC_RESET;
    end else if (!stall) begin
      pc <= pc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Retired-instruction counter
  // ---------------------------------------------------------------------------
  // Counts valid instructions even while stalled: the writeback has already
  // committed, only the fetch redirect is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= '0;
    end else if (valid) begin
      retired <= retired + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
// -----------------------------------------------------------------------------
// tb_wb_commit -- directed self-checking bench for wb_commit (NREG=16,
// PC_RESET=0). Inputs change 1 time unit after a rising edge; outputs are
// checked before the next rising edge.
// -----------------------------------------------------------------------------
module tb_wb_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, stall, regwrite, memtoreg, branch, j, jmem, and_gate;
  logic [19:0] write_destination, read_data_memory, alu_output;
  logic [19:0] adder1_output, result_shift_jump, result_adder_branch;
  logic [4:0]  ra_addr, rb_addr;
  logic [19:0] ra_data, rb_data, pc, wb_data;
  logic [15:0] retired;
  logic        wb_we;
  logic [4:0]  wb_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_commit #(.NREG(16), .PC_RESET(20'h00000)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .valid               (valid),
    .stall               (stall),
    .regwrite            (regwrite),
    .memtoreg            (memtoreg),
    .branch              (branch),
    .j                   (j),
    .jmem                (jmem),
    .and_gate            (and_gate),
    .write_destination   (write_destination),
    .read_data_memory    (read_data_memory),
    .alu_output          (alu_output),
    .adder1_output       (adder1_output),
    .result_shift_jump   (result_shift_jump),
    .result_adder_branch (result_adder_branch),
    .ra_addr             (ra_addr),
    .rb_addr             (rb_addr),
    .ra_data             (ra_data),
    .rb_data             (rb_data),
    .pc                  (pc),
    .retired             (retired),
    .wb_we               (wb_we),
    .wb_addr             (wb_addr),
    .wb_data             (wb_data)
  );

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; stall = 0; regwrite = 0; memtoreg = 0;
    branch = 0; j = 0; jmem = 0; and_gate = 0;
    write_destination = '0; read_data_memory = '0; alu_output = '0;
    adder1_output = '0; result_shift_jump = '0; result_adder_branch = '0;
    ra_addr = '0; rb_addr = '0;
  endtask

  initial begin
    logic [19:0] bypass_exp;

    // --- Reset: one edge with rst=1 ---
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("reset_pc", pc, 20'h00000);
    check("reset_retired", 20'(retired), 20'h00000);
    for (int a = 0; a < 32; a++) begin
      ra_addr = 5'(a);
      #1;
      check($sformatf("reset_ra_%0d", a), ra_data, 20'h00000);
    end

    // --- Load writeback to reg3, same-cycle read of 3 ---
    valid = 1; regwrite = 1; memtoreg = 1;
    write_destination = 20'h00003; read_data_memory = 20'hABCDE;
    alu_output = 20'h55555; adder1_output = 20'h00001;
    ra_addr = 5'd3;
    #1;
    check("load_wb_we", 20'(wb_we), 20'h1);
    check("load_wb_addr", 20'(wb_addr), 20'h3);
    check("load_wb_data", wb_data, 20'hABCDE);
`ifdef WB_COMMIT_BYPASS_EN
    bypass_exp = 20'hABCDE;
`else
    bypass_exp = 20'h00000;
`endif
    check("load_same_cycle_read", ra_data, bypass_exp);
    tick();
    check("load_reg3", ra_data, 20'hABCDE);
    check("load_pc", pc, 20'h00001);
    check("load_retired", 20'(retired), 20'h00001);
    ra_addr = 5'h13;  // upper index bit ignored -> reg3
    #1;
    check("alias_ra_13", ra_data, 20'hABCDE);

    // --- Write to index 0 is suppressed ---
    memtoreg = 0; write_destination = 20'h00000; alu_output = 20'h12345;
    adder1_output = 20'h00002; ra_addr = 5'd0;
    #1;
    check("r0_wb_we", 20'(wb_we), 20'h0);
    check("r0_wb_data", wb_data, 20'h12345);
    write_destination = 20'h00010;  // aliases to index 0 with NREG=16
    #1;
    check("r0_alias_wb_we", 20'(wb_we), 20'h0);
    tick();
    check("r0_read", ra_data, 20'h00000);
    check("r0_pc", pc, 20'h00002);

    // --- PC priority: jmem over j over branch ---
    regwrite = 0; jmem = 1; j = 1; branch = 1; and_gate = 1;
    read_data_memory = 20'h00400; result_shift_jump = 20'h00200;
    result_adder_branch = 20'h00300; adder1_output = 20'h00003;
    write_destination = 20'h00006; rb_addr = 5'd6;
    #1;
    check("jump_nolink_wb_we", 20'(wb_we), 20'h0);
    tick();
    check("jmem_pc", pc, 20'h00400);
    check("jump_nolink_reg6", rb_data, 20'h00000);
    jmem = 0;
    tick();
    check("j_pc", pc, 20'h00200);
    j = 0;
    tick();
    check("branch_taken_pc", pc, 20'h00300);
    and_gate = 0; adder1_output = 20'h00301;
    tick();
    check("branch_not_taken_pc", pc, 20'h00301);
    check("retired_6", 20'(retired), 20'h00006);

    // --- Jump and link into reg15 ---
    branch = 0; j = 1; regwrite = 1; memtoreg = 1;
    write_destination = 20'h0000F; adder1_output = 20'h00011;
    result_shift_jump = 20'h00500; read_data_memory = 20'h0EEEE;
    rb_addr = 5'd15;
    #1;
    check("jal_wb_data", wb_data, 20'h00011);
    tick();
    check("jal_reg15", rb_data, 20'h00011);
    check("jal_pc", pc, 20'h00500);

    // --- Bubble: no write, no retire, pc+1 ---
    j = 0; memtoreg = 0; valid = 0; regwrite = 1;
    write_destination = 20'h00004; alu_output = 20'h77777; ra_addr = 5'd4;
    #1;
    check("bubble_wb_we", 20'(wb_we), 20'h0);
    tick();
    check("bubble_reg4", ra_data, 20'h00000);
    check("bubble_pc", pc, 20'h00501);
    check("bubble_retired", 20'(retired), 20'h00007);

    // --- Stall for 3 edges: pc held, retires and writes continue ---
    valid = 1; stall = 1; write_destination = 20'h00005;
    alu_output = 20'h0ABCD; adder1_output = 20'h12345; ra_addr = 5'd5;
    repeat (3) tick();
    check("stall_pc", pc, 20'h00501);
    check("stall_retired", 20'(retired), 20'h0000A);
    check("stall_reg5", ra_data, 20'h0ABCD);

    // --- PC wrap FFFFF -> 00000 on a bubble ---
    stall = 0; regwrite = 0; j = 1; result_shift_jump = 20'hFFFFF;
    tick();
    check("wrap_setup_pc", pc, 20'hFFFFF);
    j = 0; valid = 0;
    tick();
    check("wrap_pc", pc, 20'h00000);
    check("wrap_retired", 20'(retired), 20'h0000B);

    // --- Reset overrides a coinciding write and PC update ---
    rst = 1; valid = 1; regwrite = 1; write_destination = 20'h00007;
    alu_output = 20'h11111; adder1_output = 20'h00999;
    tick();
    rst = 0; valid = 0; regwrite = 0;
    ra_addr = 5'd7; rb_addr = 5'd3;
    #1;
    check("rst_write_reg7", ra_data, 20'h00000);
    check("rst_clears_reg3", rb_data, 20'h00000);
    check("rst_pc", pc, 20'h00000);
    check("rst_retired", 20'(retired), 20'h00000);
    rb_addr = 5'd15;
    #1;
    check("rst_clears_reg15", rb_data, 20'h00000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
